// File: rtl/prbs_qpsk_tx_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_qpsk_tx_source : PRBS9 bit source, BPSK mapping, zero-stuffed    |
// |                       upsampling and periodic bit-error injection     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module prbs_qpsk_tx_source #(
  parameter logic [8:0] PRBS_SEED = 9'h1AA,
  parameter int         OVERSAMP  = 4,
  parameter int         NBT_SYM   = 8,
  parameter int         NBF_SYM   = 7,
  parameter int         NBT_INJ   = 16
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_inj_en,
  input  logic [NBT_INJ-1:0]        i_inj_period,
  output logic                      o_valid,
  output logic                      o_bit,
  output logic signed [NBT_SYM-1:0] o_sym,
  output logic                      o_sync,
  output logic [31:0]               o_inj_cnt
);

  // An all-zero LFSR state would lock up, so it is replaced by all-ones.
  localparam logic [8:0]                C_SEED    = (PRBS_SEED == 9'h000) ? 9'h1FF : PRBS_SEED;
  localparam int                        C_PH_W    = $clog2(OVERSAMP);
  localparam logic [C_PH_W-1:0]         C_PH_LAST = C_PH_W'(OVERSAMP - 1);
  localparam logic signed [NBT_SYM-1:0] C_POS     = NBT_SYM'((2 ** NBF_SYM) - 1);
  localparam logic signed [NBT_SYM-1:0] C_NEG     = -C_POS;

  logic [8:0]         r_state;
  logic [C_PH_W-1:0]  r_phase;
  logic [NBT_INJ-1:0] r_inj_sym_cnt;

  logic w_sym_evt;
  logic w_bit;
  logic w_inj_active;
  logic w_inj;

  assign w_sym_evt    = i_enable && (r_phase == '0);
  assign w_bit        = r_state[8];
  assign w_inj_active = i_inj_en && (i_inj_period != '0);
  // >= rather than == so that shrinking the period mid-run fires on the next symbol.
  assign w_inj        = w_inj_active && (r_inj_sym_cnt >= (i_inj_period - NBT_INJ'(1)));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= C_SEED;
      r_phase       <= '0;
      r_inj_sym_cnt <= '0;
      o_valid       <= 1'b0;
      o_bit         <= 1'b0;
      o_sym         <= '0;
      o_sync        <= 1'b0;
      o_inj_cnt     <= '0;
    end else begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      o_sym   <= '0;

      if (i_enable) begin
        r_phase <= (r_phase == C_PH_LAST) ? '0 : r_phase + C_PH_W'(1);
      end

      if (w_sym_evt) begin
        r_state <= {r_state[7:0], r_state[8] ^ r_state[4]};
        o_valid <= 1'b1;
        o_bit   <= w_bit;
        o_sync  <= (r_state == C_SEED);
        o_sym   <= (w_bit ^ w_inj) ? C_NEG : C_POS;

        if (w_inj) begin
          r_inj_sym_cnt <= '0;
          if (o_inj_cnt != '1) begin
            o_inj_cnt <= o_inj_cnt + 32'd1;
          end
        end else if (w_inj_active) begin
          r_inj_sym_cnt <= r_inj_sym_cnt + NBT_INJ'(1);
        end else begin
          r_inj_sym_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_qpsk_tx_source.sv
`default_nettype none
// Directed bench for prbs_qpsk_tx_source: reset, PRBS9 framing and period,
// error injection, period changes, enable gating and mid-run reset.
module tb_prbs_qpsk_tx_source;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_enable;
  logic               i_inj_en;
  logic [15:0]        i_inj_period;
  logic               o_valid, o_bit, o_sync;
  logic signed [7:0]  o_sym;
  logic [31:0]        o_inj_cnt;
  logic               z_valid, z_bit, z_sync;
  logic signed [7:0]  z_sym;
  logic [31:0]        z_inj_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_sync = -1;
  logic [8:0]  ref_s;
  int          ref_cnt;
  logic [31:0] ref_injn;
  int          ref_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prbs_qpsk_tx_source dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_inj_en(i_inj_en),
    .i_inj_period(i_inj_period), .o_valid(o_valid), .o_bit(o_bit),
    .o_sym(o_sym), .o_sync(o_sync), .o_inj_cnt(o_inj_cnt)
  );

  prbs_qpsk_tx_source #(.PRBS_SEED(9'h000)) dut0 (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_inj_en(i_inj_en),
    .i_inj_period(i_inj_period), .o_valid(z_valid), .o_bit(z_bit),
    .o_sym(z_sym), .o_sync(z_sync), .o_inj_cnt(z_inj_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [7:0] sym_of(input logic b);
    return b ? -8'sd127 : 8'sd127;
  endfunction

  task automatic model_reset();
    ref_s    = 9'h1AA;
    ref_cnt  = 0;
    ref_injn = 32'd0;
    ref_idx  = 0;
  endtask

  // Reference PRBS9 / injection behaviour for one symbol event.
  task automatic model_step(output logic eb, output logic esync, output logic einj);
    logic act;
    eb    = ref_s[8];
    esync = (ref_s == 9'h1AA);
    act   = i_inj_en && (i_inj_period != 16'd0);
    einj  = act && (ref_cnt >= int'(i_inj_period) - 1);
    if (einj) begin
      ref_cnt = 0;
      if (ref_injn != 32'hFFFF_FFFF) ref_injn = ref_injn + 32'd1;
    end else if (act) begin
      ref_cnt = ref_cnt + 1;
    end else begin
      ref_cnt = 0;
    end
    ref_s   = {ref_s[7:0], ref_s[8] ^ ref_s[4]};
    ref_idx = ref_idx + 1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_enable = 1'b0; i_inj_en = 1'b0; i_inj_period = 16'd0;
    repeat (3) tick();
    checks++;
    if (o_valid !== 1'b0 || o_bit !== 1'b0 || o_sync !== 1'b0) begin
      errors++; $display("FAIL reset_flags valid=%b bit=%b sync=%b required 0 0 0", o_valid, o_bit, o_sync);
    end
    checks++;
    if (o_sym !== 8'sd0) begin errors++; $display("FAIL reset_sym got %0d required 0", o_sym); end
    checks++;
    if (o_inj_cnt !== 32'd0) begin errors++; $display("FAIL reset_inj_cnt got %0d required 0", o_inj_cnt); end
    checks++;
    if (z_valid !== 1'b0 || z_bit !== 1'b0 || z_sync !== 1'b0 || z_sym !== 8'sd0 || z_inj_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_seed0 valid=%b bit=%b sync=%b sym=%0d cnt=%0d required all 0", z_valid, z_bit, z_sync, z_sym, z_inj_cnt);
    end
    i_reset = 1'b1;
    model_reset();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL idle_no_strobe got %b required 0", o_valid); end
  endtask

  task automatic test_enable_sequence();
    logic [8:0] hand;
    logic eb, esync, einj;
    hand = 9'b110101010;
    i_enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      model_step(eb, esync, einj);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== hand[8-k]) begin
        errors++; $display("FAIL first_bits k=%0d valid=%b bit=%b required 1 %b", k, o_valid, o_bit, hand[8-k]);
      end
      checks++;
      if (o_sym !== sym_of(hand[8-k])) begin
        errors++; $display("FAIL first_sym k=%0d got %0d required %0d", k, o_sym, sym_of(hand[8-k]));
      end
      checks++;
      if (o_sync !== (k == 0)) begin errors++; $display("FAIL first_sync k=%0d got %b required %b", k, o_sync, (k == 0)); end
      if (k == 0) last_sync = cyc;
      for (int q = 0; q < 3; q++) begin
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_sym !== 8'sd0 || o_sync !== 1'b0) begin
          errors++; $display("FAIL gap k=%0d q=%0d valid=%b sym=%0d sync=%b required 0 0 0", k, q, o_valid, o_sym, o_sync);
        end
      end
    end
  endtask

  task automatic test_period();
    logic eb, esync, einj;
    int idx;
    int nsync;
    nsync = 0;
    while (ref_idx <= 1022) begin
      tick();
      idx = ref_idx;
      model_step(eb, esync, einj);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== eb || o_sym !== sym_of(eb)) begin
        errors++; $display("FAIL prbs_bit idx=%0d valid=%b bit=%b sym=%0d required 1 %b %0d", idx, o_valid, o_bit, o_sym, eb, sym_of(eb));
      end
      checks++;
      if (o_sync !== ((idx % 511) == 0)) begin
        errors++; $display("FAIL prbs_sync idx=%0d got %b required %b", idx, o_sync, ((idx % 511) == 0));
      end
      if (o_sync === 1'b1) begin
        nsync++;
        checks++;
        if ((cyc - last_sync) !== 2044) begin
          errors++; $display("FAIL sync_spacing idx=%0d got %0d cycles required 2044", idx, cyc - last_sync);
        end
        last_sync = cyc;
      end
      repeat (3) tick();
    end
    checks++;
    if (nsync !== 2) begin errors++; $display("FAIL sync_count got %0d required 2", nsync); end
  endtask

  task automatic test_injection();
    logic eb, esync, einj, hinj;
    i_inj_en = 1'b1;
    i_inj_period = 16'd4;
    for (int j = 0; j < 40; j++) begin
      tick();
      model_step(eb, esync, einj);
      hinj = ((j % 4) == 3);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== eb) begin
        errors++; $display("FAIL inj_bit j=%0d valid=%b bit=%b required 1 %b", j, o_valid, o_bit, eb);
      end
      checks++;
      if (o_sym !== sym_of(eb ^ hinj)) begin
        errors++; $display("FAIL inj_sym j=%0d got %0d required %0d", j, o_sym, sym_of(eb ^ hinj));
      end
      repeat (3) tick();
    end
    checks++;
    if (o_inj_cnt !== 32'd10) begin errors++; $display("FAIL inj_count got %0d required 10", o_inj_cnt); end
  endtask

  task automatic test_period_change();
    logic eb, esync, einj, hinj;
    int per[4];
    int len[4];
    int cnt_after[4];
    per = '{100, 10, 0, 10};
    len = '{50, 23, 3, 10};
    cnt_after = '{10, 13, 13, 14};
    for (int p = 0; p < 4; p++) begin
      i_inj_period = 16'(per[p]);
      for (int j = 0; j < len[p]; j++) begin
        tick();
        model_step(eb, esync, einj);
        hinj = (p == 1 && (j % 10) == 0) || (p == 3 && j == 9);
        checks++;
        if (o_valid !== 1'b1 || o_bit !== eb || o_sym !== sym_of(eb ^ hinj)) begin
          errors++; $display("FAIL perchg p=%0d j=%0d valid=%b bit=%b sym=%0d required 1 %b %0d", p, j, o_valid, o_bit, o_sym, eb, sym_of(eb ^ hinj));
        end
        repeat (3) tick();
      end
      checks++;
      if (o_inj_cnt !== 32'(cnt_after[p])) begin
        errors++; $display("FAIL perchg_count p=%0d got %0d required %0d", p, o_inj_cnt, cnt_after[p]);
      end
    end
    i_inj_en = 1'b0;
    i_inj_period = 16'd0;
  endtask

  task automatic test_enable_gating();
    logic eb, esync, einj, last;
    tick();
    model_step(eb, esync, einj);
    last = eb;
    checks++;
    if (o_valid !== 1'b1 || o_bit !== eb) begin
      errors++; $display("FAIL gate_pre valid=%b bit=%b required 1 %b", o_valid, o_bit, eb);
    end
    tick();
    i_enable = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_sym !== 8'sd0 || o_sync !== 1'b0 || o_bit !== last) begin
        errors++; $display("FAIL gate_low c=%0d valid=%b sym=%0d sync=%b bit=%b required 0 0 0 %b", c, o_valid, o_sym, o_sync, o_bit, last);
      end
    end
    i_enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL gate_resume_phase c=%0d valid=%b required 0", c, o_valid); end
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      model_step(eb, esync, einj);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== eb || o_sym !== sym_of(eb)) begin
        errors++; $display("FAIL gate_seq s=%0d valid=%b bit=%b sym=%0d required 1 %b %0d", s, o_valid, o_bit, o_sym, eb, sym_of(eb));
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_reset_midrun();
    logic eb, esync, einj;
    logic [8:0] hand;
    int guard;
    hand = 9'b110101010;
    guard = 0;
    while ((ref_idx % 511) != 300 && guard < 600) begin
      tick();
      model_step(eb, esync, einj);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== eb) begin
        errors++; $display("FAIL run_to_300 idx=%0d valid=%b bit=%b required 1 %b", ref_idx - 1, o_valid, o_bit, eb);
      end
      repeat (3) tick();
      guard++;
    end
    tick();
    model_step(eb, esync, einj);
    checks++;
    if (o_valid !== 1'b1 || o_bit !== eb || o_inj_cnt !== ref_injn) begin
      errors++; $display("FAIL pre_reset valid=%b bit=%b cnt=%0d required 1 %b %0d", o_valid, o_bit, o_inj_cnt, eb, ref_injn);
    end
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_bit !== 1'b0 || o_sync !== 1'b0 || o_sym !== 8'sd0 || o_inj_cnt !== 32'd0) begin
      errors++; $display("FAIL async_clear valid=%b bit=%b sync=%b sym=%0d cnt=%0d required all 0", o_valid, o_bit, o_sync, o_sym, o_inj_cnt);
    end
    tick();
    tick();
    i_reset = 1'b1;
    model_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      model_step(eb, esync, einj);
      checks++;
      if (o_valid !== 1'b1 || o_bit !== hand[8-k] || o_sync !== (k == 0) || o_inj_cnt !== 32'd0) begin
        errors++; $display("FAIL restart k=%0d valid=%b bit=%b sync=%b cnt=%0d required 1 %b %b 0", k, o_valid, o_bit, o_sync, o_inj_cnt, hand[8-k], (k == 0));
      end
      checks++;
      if (z_valid !== 1'b1 || z_bit !== 1'b1 || z_sync !== (k == 0) || z_sym !== -8'sd127) begin
        errors++; $display("FAIL seed0_seq k=%0d valid=%b bit=%b sync=%b sym=%0d required 1 1 %b -127", k, z_valid, z_bit, z_sync, z_sym, (k == 0));
      end
      repeat (3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_enable_sequence();
    test_period();
    test_injection();
    test_period_change();
    test_enable_gating();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
